// File: rtl/mips_fetch_pkg.sv
// rtl/mips_fetch_pkg.sv - shared types and constants for the MIPS fetch front end
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - one-entry {instr, pc} holding buffer for decode stalls
module fetch_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic              i_unload,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_instr,
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_full,
  output logic [DATA_W-1:0] o_instr,
  output logic [ADDR_W-1:0] o_pc
);

  logic              r_full;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_full  <= 1'b0;
      r_instr <= '0;
      r_pc    <= '0;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full  <= 1'b1;
      r_instr <= i_instr;
      r_pc    <= i_pc;
    end else if (i_unload) begin
      r_full <= 1'b0;
    end
  end

  assign o_full  = r_full;
  assign o_instr = r_instr;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - program counter, imem req/ack fetch and IF/ID register bank
module fetch_pc_unit
  import mips_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic [ADDR_W-1:0] if_pc_plus4
);

  fetch_state_t      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drain_addr;
  logic              r_if_valid;
  logic [DATA_W-1:0] r_if_instr;
  logic [ADDR_W-1:0] r_if_pc;
  logic [ADDR_W-1:0] r_if_pc_plus4;

  logic              w_accept;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_redirect_pc;
  logic              w_skid_load;
  logic              w_skid_unload;
  logic              w_skid_full;
  logic [DATA_W-1:0] w_skid_instr;
  logic [ADDR_W-1:0] w_skid_pc;

  assign w_accept      = !stall || !r_if_valid;
  assign w_pc_next     = r_pc + ADDR_W'(PC_INC);
  assign w_redirect_pc = redirect_pc & ~ADDR_W'(3);
  assign w_skid_load   = (r_state == FETCH) && imem_ack && !w_accept && !redirect;
  assign w_skid_unload = (r_state == HOLD) && !stall && !redirect;

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .reset    (reset),
    .i_load   (w_skid_load),
    .i_unload (w_skid_unload),
    .i_clear  (redirect),
    .i_instr  (imem_rdata),
    .i_pc     (r_pc),
    .o_full   (w_skid_full),
    .o_instr  (w_skid_instr),
    .o_pc     (w_skid_pc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_drain_addr  <= '0;
      r_if_valid    <= 1'b0;
      r_if_instr    <= '0;
      r_if_pc       <= '0;
      r_if_pc_plus4 <= '0;
    end else if (redirect) begin
      r_if_valid <= 1'b0;
      r_pc       <= w_redirect_pc;
      // An unacknowledged request must still complete at its original address.
      if ((r_state != HOLD) && !imem_ack) begin
        r_state <= DRAIN;
        if (r_state == FETCH) r_drain_addr <= r_pc;
      end else begin
        r_state <= FETCH;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) begin
            r_pc <= w_pc_next;
            if (w_accept) begin
              r_if_valid    <= 1'b1;
              r_if_instr    <= imem_rdata;
              r_if_pc       <= r_pc;
              r_if_pc_plus4 <= w_pc_next;
            end else begin
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall && w_skid_full) begin
            r_if_valid    <= 1'b1;
            r_if_instr    <= w_skid_instr;
            r_if_pc       <= w_skid_pc;
            r_if_pc_plus4 <= w_skid_pc + ADDR_W'(PC_INC);
            r_state       <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) r_state <= FETCH;
        end
        default: r_state <= FETCH;
      endcase
    end
  end

  assign imem_req    = reset && (r_state != HOLD);
  assign imem_addr   = (r_state == DRAIN) ? r_drain_addr : r_pc;
  assign if_valid    = r_if_valid;
  assign if_instr    = r_if_instr;
  assign if_pc       = r_if_pc;
  assign if_pc_plus4 = r_if_pc_plus4;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - randomized self-checking bench for fetch_pc_unit
module tb_fetch_pc_unit;

  localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_pc, imem_rdata;
  logic        imem_req, if_valid;
  logic [31:0] imem_addr, if_instr, if_pc, if_pc_plus4;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .RESET_PC (TB_RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pc_plus4 (if_pc_plus4)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Reference model: architectural PC, delivered slot, pending-delivery queue,
  // and a "discard the next returned word" marker with its address.
  logic [31:0] m_pc, m_i, m_p, m_p4, m_disc_addr;
  bit          m_v, m_disc;
  logic [63:0] m_q[$];

  int cnt = 0, lat = 0, lat_min = 0, lat_max = 0;

  task automatic model_reset();
    m_pc   = TB_RESET_PC;
    m_v    = 1'b0;
    m_i    = '0;
    m_p    = '0;
    m_p4   = '0;
    m_disc = 1'b0;
    m_q.delete();
  endtask

  task automatic step(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc);
    bit          exp_req, ack;
    logic [31:0] exp_addr, rd;
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    #1;
    exp_req  = rst && (m_q.size() == 0);
    exp_addr = m_disc ? m_disc_addr : m_pc;
    check("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", imem_addr, exp_addr);
    check("if_valid", 32'(if_valid), 32'(m_v));
    check("if_instr", if_instr, m_i);
    check("if_pc", if_pc, m_p);
    check("if_pc_plus4", if_pc_plus4, m_p4);

    if (!rst) begin
      cnt = 0;
    end else if (imem_req) begin
      if (cnt == 0) lat = $urandom_range(lat_max, lat_min);
      if (cnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        cnt        = 0;
      end else begin
        cnt++;
      end
    end
    ack = imem_ack;
    rd  = imem_rdata;
    #1;

    if (!rst) begin
      model_reset();
    end else if (rdr) begin
      m_v = 1'b0;
      m_q.delete();
      if (exp_req && !ack) begin
        if (!m_disc) begin
          m_disc      = 1'b1;
          m_disc_addr = m_pc;
        end
      end else begin
        m_disc = 1'b0;
      end
      m_pc = rpc & ~32'h3;
    end else if (m_q.size() != 0) begin
      if (!stl) begin
        {m_i, m_p} = m_q.pop_front();
        m_p4 = m_p + 32'd4;
        m_v  = 1'b1;
      end
    end else if (ack) begin
      if (m_disc) begin
        m_disc = 1'b0;
      end else if (!stl || !m_v) begin
        m_v  = 1'b1;
        m_i  = rd;
        m_p  = m_pc;
        m_p4 = m_pc + 32'd4;
        m_pc = m_pc + 32'd4;
      end else begin
        m_q.push_back({rd, m_pc});
        m_pc = m_pc + 32'd4;
      end
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_ack    = 1'b0;
    imem_rdata  = '0;
    model_reset();
    @(posedge clk);
    #1;

    step(0, 0, 0, 0);
    step(0, 1, 1, 32'h44);

    repeat (6) step(1, 0, 0, 0);

    repeat (3) step(1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 0);

    lat_min = 2; lat_max = 2;
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h103);
    repeat (8) step(1, 0, 0, 0);

    lat_min = 0; lat_max = 0;
    repeat (4) step(1, 0, 0, 0);
    repeat (2) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h200);
    repeat (4) step(1, 0, 0, 0);

    step(1, 0, 1, 32'hFFFF_FFF8);
    repeat (5) step(1, 0, 0, 0);

    lat_min = 2; lat_max = 2;
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'h40);
    step(0, 0, 0, 0);
    repeat (8) step(1, 0, 0, 0);

    lat_min = 0; lat_max = 3;
    repeat (3000) begin
      step($urandom_range(99) >= 2, $urandom_range(99) < 30,
           $urandom_range(99) < 10, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Instruction-fetch front end of the MIPS pipeline. It owns the program counter and issues word requests to instruction memory over a req/ack handshake. It delivers {instr, pc, pc+4} with a valid flag into the IF/ID register bank, which is built from D flip-flops. It also handles decode-stage stalls (one-entry skid buffer) and branch/jump redirects (flush plus drain of any in-flight request).

Parameters:
ADDR_W, 32, PC and memory address width
DATA_W, 32, instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  single clock, all state updates on posedge
reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block
stall  in  1  decode cannot accept; hold if_* outputs
redirect  in  1  taken branch/jump resolved this cycle
redirect_pc  in  ADDR_W  target address; bits [1:0] ignored and forced to 00
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  word-aligned fetch address
imem_ack  in  1  imem_rdata valid; may assert in the same cycle as imem_req (zero-wait)
imem_rdata  in  DATA_W  instruction word
if_valid  out  1  if_* holds a live instruction
if_instr  out  DATA_W  fetched instruction
if_pc  out  ADDR_W  address of if_instr
if_pc_plus4  out  ADDR_W  if_pc + 4 (mod 2^ADDR_W)

Behaviour:
- Reset (reset==0 at a posedge):
  - pc<=RESET_PC, state<=FETCH, skid empty.
  - if_valid, if_instr, if_pc, if_pc_plus4 all <=0.
  - imem_req is forced 0 while reset==0.
- State machine with three states:
  - FETCH: request pc. imem_req=1, imem_addr=pc.
  - HOLD: skid buffer full, downstream stalled. imem_req=0.
  - DRAIN: a redirect landed while a request was outstanding. imem_req=1, imem_addr=old address; the returning data is discarded.
- Handshake: once raised, imem_req and imem_addr stay stable until the cycle imem_ack=1. A request is never withdrawn.
- "accept" means !stall || !if_valid. A stall while if_valid=0 is ignored.
- Priority each cycle: reset > redirect > ack/stall.
- FETCH:
  - ack & accept: if_*<={1, rdata, pc, pc+4}; pc<=pc+4; stay in FETCH. With zero-wait memory this gives 1 instruction per cycle.
  - ack & !accept: skid<={rdata, pc}; pc<=pc+4; go to HOLD. if_* unchanged.
  - no ack: hold everything.
- HOLD:
  - stall==0: if_*<={1, skid}; skid empty; go to FETCH.
  - stall==1: hold.
- Redirect, taken in any state:
  - if_valid<=0 and skid emptied in the same edge.
  - pc<=redirect_pc & ~3.
  - If in FETCH or DRAIN with imem_ack==0, go to DRAIN, because a request is outstanding. Otherwise go to FETCH.
  - Redirect with ack in the same cycle: the data is discarded, go to FETCH, and the next request uses the new pc in the following cycle.
  - Redirect during DRAIN: update pc and stay in DRAIN.
- DRAIN: on ack, discard the data and go to FETCH at the current pc. if_valid stays 0.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W (32'hFFFF_FFFC -> 0).
  - if_pc_plus4 is registered together with if_pc, not recomputed combinationally.
- Latency: zero-wait memory gives 1 cycle from imem_req/ack to if_valid. After reset is released, the first if_valid is seen 1 cycle after the first ack.
- Reset asserted mid-request (any state): state is abandoned and nothing is drained. The memory side must tolerate a dropped request.

Decomposition:
- Package mips_fetch_pkg holds:
  - the fetch_state_t enum (FETCH, HOLD, DRAIN)
  - PC_INC = 4
  - the default RESET_PC constant
- One sub-module, fetch_skid_buf: a one-entry buffer of {instr, pc} with load, unload and clear, a full flag, and the same clk/reset convention.
- pc and if_* registers stay inline.

Test Plan:
1. Streaming: reset released, zero-wait memory returning the word = address, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; if_instr/if_pc = 0,4,8 with if_valid=1 from the 2nd cycle onward; if_pc_plus4 = if_pc+4.
2. Stall/skid: stall=1 for 3 cycles while if_pc=8 -> if_* holds 8; the word at 12 is captured in skid; imem_req=0 in HOLD; after stall drops, if_pc=12 next cycle, then 16.
3. Redirect with 2-cycle memory latency: redirect=1, redirect_pc=0x103 while the request at 0x20 is outstanding -> if_valid=0 next cycle; imem_addr stays 0x20 until ack; that data is discarded; the next request is at 0x100.
4. Simultaneous stall and redirect with the skid full -> flush wins: skid empty, if_valid=0, fetch resumes at the target.
5. Wrap: RESET_PC=32'hFFFF_FFF8 -> fetches FFFF_FFF8, FFFF_FFFC, 0000_0000; if_pc_plus4 for FFFF_FFFC is 0.
6. Reset mid-DRAIN: reset=0 for one cycle -> all if_* = 0, imem_req=0 during reset; afterwards fetch restarts at RESET_PC and the stale ack is ignored.
